// File: rtl/relu_neuron_array_pkg.sv
// Shared types and helpers for the ReLU neuron array: FSM states,
// accumulator width and the signed saturation limits of an N-bit result.
package relu_pkg;

    typedef enum logic [0:0] {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    // Full-precision products plus headroom for k_max beats.
    function automatic int acc_width(int n, int k_max);
        return 2 * n + $clog2(k_max);
    endfunction

    // Largest positive N-bit signed value.
    function automatic longint sat_hi(int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    // Most negative N-bit signed value.
    function automatic longint sat_lo(int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

endpackage

// File: rtl/relu_neuron_array_if.sv
// Stream bundle for the neuron array: input beats (x broadcast, one weight
// per lane) and activated result words, each with valid/ready.
interface relu_neuron_array_if #(
    parameter int N     = 18,
    parameter int LANES = 4
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [N-1:0]         in_x;
    logic [LANES*N-1:0]   in_w;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*N-1:0]   out_data;

    modport master (
        output in_valid, in_last, in_x, in_w, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_last, in_x, in_w, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/relu_neuron_array_mac_lane.sv
// One neuron lane: signed MAC with clear/enable, plus combinational
// requantise + ReLU (leaky when RELU_LEAKY_EN is defined) of acc_next.
// Ports: clk, rst (async active-low), clr, en, x, w, act (N-bit result).
module mac_lane
    import relu_pkg::*;
#(
    parameter int N          = 18,
    parameter int ACC_W      = 38,
    parameter int SHIFT      = 18,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic signed [N-1:0] x,
    input  logic signed [N-1:0] w,
    output logic signed [N-1:0] act
);
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(N));

    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] y;

    assign prod     = x * w;
    assign acc_next = en ? acc_q + ACC_W'(prod) : acc_q;
    assign y        = acc_next >>> SHIFT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_next;
        end
    end

`ifdef RELU_LEAKY_EN
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(N));
    logic signed [ACC_W-1:0] yl;
    assign yl = y >>> LEAK_SHIFT;
`endif

    always_comb begin
        act = '0;
        if (y < 0) begin
`ifdef RELU_LEAKY_EN
            act = (yl < LO) ? LO[N-1:0] : yl[N-1:0];
`else
            act = '0;
`endif
        end else if (y > HI) begin
            act = HI[N-1:0];
        end else begin
            act = y[N-1:0];
        end
    end

endmodule

// File: rtl/relu_neuron_array.sv
// Multi-lane neuron engine: LANES MACs share a broadcast activation, then
// requantise/ReLU/saturate into a held result. Optional: RELU_LEAKY_EN.
// Ports: clk, rst (async active-low), bus (slave stream), err_ovf (sticky).
module relu_neuron_array
    import relu_pkg::*;
#(
    parameter int N          = 18,
    parameter int LANES      = 4,
    parameter int K_MAX      = 256,
    parameter int SHIFT      = 18,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    relu_neuron_array_if.slave   bus,
    output logic                 err_ovf
);
    localparam int ACC_W = acc_width(N, K_MAX);
    localparam int CW    = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [LANES*N-1:0]   data_q;
    logic [LANES*N-1:0]   lane_act;
    logic                 fire;
    logic                 at_max;
    logic                 close;

    // A vector closes on its last beat, or is forced shut on beat K_MAX.
    always_comb begin
        state_d = state_q;
        at_max  = (cnt_q == CW'(K_MAX - 1));
        fire    = (state_q == S_ACC) && bus.in_valid;
        close   = fire && (bus.in_last || at_max);
        unique case (state_q)
            S_ACC:   if (close) state_d = S_OUT;
            S_OUT:   if (bus.out_ready) state_d = S_ACC;
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_ACC;
            cnt_q   <= '0;
            data_q  <= '0;
            err_ovf <= 1'b0;
        end else begin
            state_q <= state_d;
            if (close) begin
                cnt_q  <= '0;
                data_q <= lane_act;
                if (!bus.in_last) err_ovf <= 1'b1;
            end else if (fire) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state_q == S_ACC);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_data  = data_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(
            .N          (N),
            .ACC_W      (ACC_W),
            .SHIFT      (SHIFT),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (close),
            .en  (fire),
            .x   (bus.in_x),
            .w   (bus.in_w[i*N +: N]),
            .act (lane_act[i*N +: N])
        );
    end

endmodule

// File: tb/tb_relu_neuron_array.sv
// Self-checking bench for relu_neuron_array (N=8, LANES=2, K_MAX=4,
// SHIFT=2, LEAK_SHIFT=1); honours RELU_LEAKY_EN for expected values.
module tb_relu_neuron_array;
    localparam int N  = 8;
    localparam int L  = 2;
    localparam int KM = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    relu_neuron_array_if #(.N(N), .LANES(L)) bus ();

    relu_neuron_array #(
        .N(N), .LANES(L), .K_MAX(KM), .SHIFT(2), .LEAK_SHIFT(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_ovf (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Floor division, then ReLU / leaky ReLU, then saturation to N bits.
    function automatic int floordiv(int a, int d);
        return (a >= 0) ? a / d : -((-a + d - 1) / d);
    endfunction

    function automatic int activate(int a);
        int y;
        y = floordiv(a, 4);
        if (y < 0) begin
`ifdef RELU_LEAKY_EN
            y = floordiv(y, 2);
            return (y < -128) ? -128 : y;
`else
            return 0;
`endif
        end
        return (y > 127) ? 127 : y;
    endfunction

    // Transaction-level reference: beats accumulate, a vector closes on
    // in_last or on its KM-th beat, then is held until taken.
    int m_acc[L];
    int m_out[L];
    int m_cnt;
    bit m_hold;
    bit m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < L; i++) begin
                m_acc[i] = 0;
                m_out[i] = 0;
            end
            m_cnt  = 0;
            m_hold = 0;
            m_err  = 0;
        end else if (!m_hold && bus.in_valid) begin
            for (int i = 0; i < L; i++)
                m_acc[i] += int'($signed(bus.in_x)) *
                            int'($signed(bus.in_w[i*N +: N]));
            m_cnt++;
            if (bus.in_last || m_cnt == KM) begin
                if (!bus.in_last) m_err = 1;
                for (int i = 0; i < L; i++) begin
                    m_out[i] = activate(m_acc[i]);
                    m_acc[i] = 0;
                end
                m_cnt  = 0;
                m_hold = 1;
            end
        end else if (m_hold && bus.out_ready) begin
            m_hold = 0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_in_ready", 64'(bus.in_ready), 64'(!m_hold));
        chk("cyc_out_valid", 64'(bus.out_valid), 64'(m_hold));
        chk("cyc_err_ovf", 64'(err_ovf), 64'(m_err));
        if (m_hold)
            for (int i = 0; i < L; i++)
                chk("cyc_lane", 64'(bus.out_data[i*N +: N]),
                    64'(m_out[i][N-1:0]));
    end

    // Drive one beat starting just after an edge; returns just after the
    // edge that accepts it.
    task automatic send(int x, int w0, int w1, bit last);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.in_x     = N'(x);
        bus.in_w     = {N'(w1), N'(w0)};
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic bubble(int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b1;
            bus.in_x     = 8'h55;
            @(posedge clk);
            #1;
        end
        bus.in_last = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_x      = '0;
        bus.in_w      = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_err", 64'(err_ovf), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic dot product: acc 18/-18 -> y 4/-5.
        send(2, 3, -3, 0);
        send(2, 3, -3, 0);
        chk("basic_not_yet", 64'(bus.out_valid), 64'd0);
        send(2, 3, -3, 1);
        chk("basic_valid", 64'(bus.out_valid), 64'd1);
`ifdef RELU_LEAKY_EN
        chk("basic_data", 64'(bus.out_data), 64'hFD04);
`else
        chk("basic_data", 64'(bus.out_data), 64'h0004);
`endif
        take();
        chk("basic_ready_after", 64'(bus.in_ready), 64'd1);

        // Saturation: acc 64516 -> y 16129 -> 127.
        for (int i = 0; i < 4; i++) send(127, 127, 0, i == 3);
        chk("sat_data", 64'(bus.out_data), 64'h007F);
        chk("sat_err", 64'(err_ovf), 64'd0);

        // Backpressure on the saturated result.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_data", 64'(bus.out_data), 64'h007F);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        take();
        chk("bp_release", 64'(bus.in_ready), 64'd1);

        // Forced close: acc 4/8 -> 1/2.
        for (int i = 0; i < 4; i++) send(1, 1, 2, 0);
        chk("force_valid", 64'(bus.out_valid), 64'd1);
        chk("force_data", 64'(bus.out_data), 64'h0201);
        chk("force_err", 64'(err_ovf), 64'd1);
        take();
        send(4, 5, -1, 1);
`ifdef RELU_LEAKY_EN
        chk("after_force_data", 64'(bus.out_data), 64'hFF05);
`else
        chk("after_force_data", 64'(bus.out_data), 64'h0005);
`endif
        chk("after_force_err", 64'(err_ovf), 64'd1);
        take();

        // Bubbles (in_last ignored without in_valid) and single beat.
        bubble(3);
        chk("bubble_idle", 64'(bus.out_valid), 64'd0);
        send(1, 8, 0, 1);
        chk("single_data", 64'(bus.out_data), 64'h0002);
        take();
        send(1, 8, 0, 0);
        bubble(2);
        send(1, 8, 0, 1);
        chk("toggle_data", 64'(bus.out_data), 64'h0004);
        take();

        // Reset mid-vector.
        send(10, 10, 10, 0);
        send(10, 10, 10, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_out_data", 64'(bus.out_data), 64'd0);
        chk("mid_rst_err", 64'(err_ovf), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(1, 4, 4, 1);
        chk("post_rst_data", 64'(bus.out_data), 64'h0101);
        take();
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
